ttl_adder_seq: RTL
==================

Name: ttl_adder_seq

Overview:
- Nibble-serial sequencer that time-shares one external 4-bit fast-carry adder (74283-style) to perform a multi-nibble add or subtract.
- Latches two operands on a start strobe. Feeds one nibble pair per clock, least significant first, holding the inter-nibble carry in a register.
- Presents the full result with carry and signed-overflow flags.
- Used wherever the board logic chains adders for wide sums but the core needs one shared adder model instead of a ripple chain.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 2..8.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A-B; latched with operands.
- a_in  in  4*NIBBLES  operand A; latched on accepted start.
- b_in  in  4*NIBBLES  operand B; latched on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  4*NIBBLES  sum/difference; held until next accepted start.
- carry_out  out  1  final adder carry. For sub, 1 = no borrow.
- overflow  out  1  two's-complement overflow of the full-width operation.
- adder_a  out  4  nibble A to shared adder.
- adder_b  out  4  nibble B (inverted when sub) to shared adder.
- adder_cin  out  1  carry-in to shared adder.
- adder_sum  in  4  adder sum output.
- adder_cout  in  1  adder carry output.

Behaviour:
- Reset (sync, rst=1 at edge):
  - State = IDLE; index = 0; carry register = 0.
  - Outputs: busy=0, done=0, result=0, carry_out=0, overflow=0.
  - Latched operands cleared.
  - rst has priority over every other input.
  - Reset mid-RUN aborts the operation; no done pulse; result forced to 0.
- States:
  - IDLE: busy=0. On start=1, latch a_in, b_in, sub; set carry register = sub (the +1 of two's complement); index=0; go to RUN. With start=0, stay in IDLE.
  - RUN: busy=1. Combinationally drive:
    - adder_a = A[4*index+:4]
    - adder_b = B[4*index+:4] XOR {4{sub}}
    - adder_cin = carry register
  - At each edge in RUN: result[4*index+:4] <= adder_sum; carry register <= adder_cout; index++.
  - When index == NIBBLES-1 at the edge, go to DONE. On that same edge, capture:
    - carry_out <= adder_cout
    - overflow <= (adder_a[3] == adder_b[3]) && (adder_sum[3] != adder_a[3]), using the effective (inverted) B.
  - DONE: done=1, busy=1 for exactly one cycle; unconditionally go to IDLE.
- Adder ports in IDLE/DONE: adder_a=0, adder_b=0, adder_cin=0.
- Latency:
  - Start accepted at edge 0.
  - RUN occupies edges 1..NIBBLES.
  - done is high during the cycle following edge NIBBLES, so a new start is accepted at edge NIBBLES+2 at earliest.
  - Throughput: one operation per NIBBLES+2 cycles.
- start while busy is ignored: not queued, operands not relatched. start held high continuously re-triggers on each return to IDLE.
- Operands changing on a_in/b_in during RUN have no effect.
- result, carry_out and overflow are stable from the done cycle until the next accepted start.
- During RUN, lower nibbles of result update progressively. Consumers must sample only on done.
- Timing: the adder path is combinational within one cycle; simulation delays in the adder model (≤15 ns) must fit the clock period. The block adds no registering on adder_sum/adder_cout.
- Width: NIBBLES*4 result bits; carry beyond MSB appears only on carry_out and is never wrapped into result.

Test Plan:
- NIBBLES=4; add 0x1234 + 0x0FCD → done after 4 RUN cycles; result=0x2201, carry_out=0, overflow=0; adder_a sequence 4,3,2,1.
- Add 0xFFFF + 0x0001 → result=0x0000, carry_out=1, overflow=0; carry register 1 on every intermediate nibble.
- Add 0x7FFF + 0x0001 → result=0x8000, carry_out=0, overflow=1.
- Sub 0x0005 − 0x0007 → adder_cin=1 on first nibble; result=0xFFFE, carry_out=0 (borrow), overflow=0.
- Sub 0x8000 − 0x0001 → result=0x7FFF, carry_out=1, overflow=1.
- Pulse start again at RUN cycle 2 with different operands → ignored, first result unchanged. Separately, assert rst at RUN cycle 2 → next cycle busy=0, result=0, and no done pulse ever appears.

Source files
------------

// File: rtl/ttl_adder_seq.sv
// ttl_adder_seq: nibble-serial add/subtract sequencer that time-shares one external 4-bit adder
module ttl_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic [3:0]           adder_a,
    output logic [3:0]           adder_b,
    output logic                 adder_cin,
    input  logic [3:0]           adder_sum,
    input  logic                 adder_cout
);
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state;
    logic [IW-1:0]        idx;
    logic                 cry;
    logic                 sub_r;
    logic [4*NIBBLES-1:0] a_r;
    logic [4*NIBBLES-1:0] b_r;
    logic                 run;
    assign run = state == RUN;
    always_comb begin
        adder_a   = run ? a_r[{idx, 2'b00} +: 4] : 4'd0;
        adder_b   = run ? b_r[{idx, 2'b00} +: 4] ^ {4{sub_r}} : 4'd0;
        adder_cin = run & cry;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cry       <= 1'b0;
            sub_r     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= a_in;
                    b_r   <= b_in;
                    sub_r <= sub;
                    cry   <= sub;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= adder_sum;
                    cry <= adder_cout;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        carry_out <= adder_cout;
                        overflow  <= (adder_a[3] == adder_b[3]) && (adder_sum[3] != adder_a[3]);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
